// File: rtl/stack_arb_pkg.sv
// stack_arb_pkg: shared encodings for the j1b stack arbiter.
// Holds the debug command codes, the stack delta codes, the FSM state
// type and the helper that sizes the depth counter.
package stack_arb_pkg;

  // Debug command encodings carried on dbg_cmd.
  localparam logic [1:0] CMD_PEEK  = 2'b00;
  localparam logic [1:0] CMD_PUSH  = 2'b01;
  localparam logic [1:0] CMD_POP   = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  // Stack delta encodings: bit 0 = move, bit 1 = pop direction.
  localparam logic [1:0] D_PUSH = 2'b01;
  localparam logic [1:0] D_NONE = 2'b10;
  localparam logic [1:0] D_POP  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CLEAR,
    S_ACK
  } state_t;

  // Counter width able to hold 0..entries+1 (tail entries plus the head).
  function automatic int depth_w(input int entries);
    return $clog2(entries + 2);
  endfunction

endpackage

// File: rtl/stack_arb_if.sv
// stack_arb_if: debug requester bus (e.g. a UART monitor) into the arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface stack_arb_if #(
  parameter int DW = 32
);
  logic          req;
  logic [1:0]    cmd;
  logic [DW-1:0] wd;
  logic          ack;
  logic [DW-1:0] rdata;

  modport master (output req, output cmd, output wd, input ack, input rdata);
  modport slave  (input req, input cmd, input wd, output ack, output rdata);
endinterface

// File: rtl/stack_depth_ctr.sv
// stack_depth_ctr: live entry count of the controlled stack plus sticky
// overflow/underflow flags. The stack always shifts on a move, so saturation
// only affects the count, never the stack itself.
// Optional macro STACK_ARB_HWM_EN adds a high-water-mark output.
module stack_depth_ctr
  import stack_arb_pkg::*;
#(
  parameter int DEPTH = 18
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [1:0]                  delta,
  input  logic                        clr,
  output logic [depth_w(DEPTH)-1:0]   depth,
  output logic                        ovf,
  output logic                        unf
`ifdef STACK_ARB_HWM_EN
  ,
  output logic [depth_w(DEPTH)-1:0]   hwm
`endif
);

  localparam int DEPW = depth_w(DEPTH);
  localparam logic [DEPW-1:0] FULL = DEPW'(DEPTH + 1);

  // Track depth from the delta actually driven to the stack; flags are sticky
  // until a CLEAR completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      if (delta == D_PUSH) begin
        if (depth == FULL) ovf <= 1'b1;
        else               depth <= depth + 1'b1;
      end else if (delta == D_POP) begin
        if (depth == '0) unf <= 1'b1;
        else             depth <= depth - 1'b1;
      end
      if (clr) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end
    end
  end

`ifdef STACK_ARB_HWM_EN
  // High-water mark follows the registered depth one cycle later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              hwm <= '0;
    else if (clr)           hwm <= '0;
    else if (depth > hwm)   hwm <= depth;
  end
`endif

endmodule

// File: rtl/stack_arb.sv
// stack_arb: arbiter/sequencer in front of one j1b data or return stack.
// The core owns the stack port while idle; a debug requester may PEEK, PUSH,
// POP or CLEAR only while the core is halted. CLEAR pops until empty.
// Optional macro STACK_ARB_HWM_EN adds the hwm output.
module stack_arb
  import stack_arb_pkg::*;
#(
  parameter int DEPTH = 18,
  parameter int DW    = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        core_we,
  input  logic [1:0]                  core_delta,
  input  logic [DW-1:0]               core_wd,
  input  logic                        core_halt,
  output logic                        core_stall,
  stack_arb_if.slave                  dbg,
  input  logic [DW-1:0]               stk_rd,
  output logic                        stk_we,
  output logic [1:0]                  stk_delta,
  output logic [DW-1:0]               stk_wd,
  output logic [depth_w(DEPTH)-1:0]   depth,
  output logic                        ovf,
  output logic                        unf
`ifdef STACK_ARB_HWM_EN
  ,
  output logic [depth_w(DEPTH)-1:0]   hwm
`endif
);

  state_t        state, state_nxt;
  logic [1:0]    cmd_q;
  logic [DW-1:0] wd_q;
  logic [DW-1:0] rdata_q;
  logic          accept;
  logic          capture;
  logic          clr_done;
  logic          ack;

  assign accept  = (state == S_IDLE) && dbg.req && core_halt;
  assign capture = (state == S_EXEC) && ((cmd_q == CMD_PEEK) || (cmd_q == CMD_POP));

  assign dbg.ack   = ack;
  assign dbg.rdata = rdata_q;

  // State register and command latch; the command is frozen at accept so the
  // requester may change its bus while the sequence runs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cmd_q <= CMD_PEEK;
      wd_q  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cmd_q <= dbg.cmd;
        wd_q  <= dbg.wd;
      end
    end
  end

  // Read data is sampled from the head before any pop of the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        rdata_q <= '0;
    else if (capture) rdata_q <= stk_rd;
  end

  // Next state and stack port mux: the core drives the port only in IDLE.
  always_comb begin
    state_nxt  = state;
    stk_we     = 1'b0;
    stk_delta  = D_NONE;
    stk_wd     = wd_q;
    core_stall = 1'b1;
    ack        = 1'b0;
    clr_done   = 1'b0;
    unique case (state)
      S_IDLE: begin
        core_stall = 1'b0;
        stk_we     = core_we;
        stk_delta  = core_delta;
        stk_wd     = core_wd;
        if (accept) state_nxt = (dbg.cmd == CMD_CLEAR) ? S_CLEAR : S_EXEC;
      end
      S_EXEC: begin
        case (cmd_q)
          CMD_PUSH: begin
            stk_we    = 1'b1;
            stk_delta = D_PUSH;
          end
          CMD_POP:  stk_delta = D_POP;
          default:  stk_delta = D_NONE;
        endcase
        state_nxt = S_ACK;
      end
      S_CLEAR: begin
        if (depth != '0) begin
          stk_delta = D_POP;
        end else begin
          clr_done  = 1'b1;
          state_nxt = S_ACK;
        end
      end
      S_ACK: begin
        ack       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  stack_depth_ctr #(
    .DEPTH (DEPTH)
  ) u_depth (
    .clk   (clk),
    .reset (reset),
    .delta (stk_delta),
    .clr   (clr_done),
    .depth (depth),
    .ovf   (ovf),
    .unf   (unf)
`ifdef STACK_ARB_HWM_EN
    ,
    .hwm   (hwm)
`endif
  );

endmodule

// File: tb/tb_stack_arb.sv
// tb_stack_arb: directed bench for stack_arb with a transaction-level model.
// A simple shift-register stack environment feeds stk_rd back to the DUT.
module tb_stack_arb;
  import stack_arb_pkg::*;

  localparam int DEPTH = 18;
  localparam int DW    = 32;
  localparam int DEPW  = depth_w(DEPTH);

  logic            clk = 1'b0;
  logic            reset;
  logic            core_we;
  logic [1:0]      core_delta;
  logic [DW-1:0]   core_wd;
  logic            core_halt;
  logic            core_stall;
  logic [DW-1:0]   stk_rd;
  logic            stk_we;
  logic [1:0]      stk_delta;
  logic [DW-1:0]   stk_wd;
  logic [DEPW-1:0] depth;
  logic            ovf;
  logic            unf;
`ifdef STACK_ARB_HWM_EN
  logic [DEPW-1:0] hwm;
`endif

  int compared   = 0;
  int mismatched = 0;

  stack_arb_if #(.DW(DW)) bus ();

  stack_arb #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .core_we    (core_we),
    .core_delta (core_delta),
    .core_wd    (core_wd),
    .core_halt  (core_halt),
    .core_stall (core_stall),
    .dbg        (bus),
    .stk_rd     (stk_rd),
    .stk_we     (stk_we),
    .stk_delta  (stk_delta),
    .stk_wd     (stk_wd),
    .depth      (depth),
    .ovf        (ovf),
    .unf        (unf)
`ifdef STACK_ARB_HWM_EN
    ,
    .hwm        (hwm)
`endif
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Stack environment: head at index 0, DEPTH tail entries; the bottom entry is
  // lost on a push and duplicated on a pop.
  logic [DW-1:0] stk [0:DEPTH];
  assign stk_rd = stk[0];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i <= DEPTH; i++) stk[i] <= '0;
    end else if (stk_delta == 2'b01) begin
      for (int i = 1; i <= DEPTH; i++) stk[i] <= stk[i-1];
      if (stk_we) stk[0] <= stk_wd;
    end else if (stk_delta == 2'b11) begin
      for (int i = 0; i < DEPTH; i++) stk[i] <= stk[i+1];
    end else if (stk_we && stk_delta == 2'b00) begin
      stk[0] <= stk_wd;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each debug command expands into a list of expected port cycles.
  typedef struct {
    logic          we;
    logic [1:0]    delta;
    logic [DW-1:0] wd;
    logic          stall;
    logic          ack;
    logic          cap;
    logic          clr_done;
  } step_t;

  step_t         q[$];
  step_t         e;
  int            m_depth = 0;
  logic          m_ovf   = 1'b0;
  logic          m_unf   = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  int            m_hwm   = 0;

  function automatic step_t mk(input logic we, input logic [1:0] d, input logic [DW-1:0] wd,
                               input logic ack, input logic cap, input logic cd);
    step_t s;
    s.we = we; s.delta = d; s.wd = wd; s.stall = 1'b1;
    s.ack = ack; s.cap = cap; s.clr_done = cd;
    return s;
  endfunction

  // Compare every cycle mid-period, then advance the model past the next edge.
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      m_depth = 0; m_ovf = 1'b0; m_unf = 1'b0; m_rdata = '0; m_hwm = 0;
    end
    if (q.size() > 0) begin
      e = q[0];
    end else begin
      e.we = core_we; e.delta = core_delta; e.wd = core_wd;
      e.stall = 1'b0; e.ack = 1'b0; e.cap = 1'b0; e.clr_done = 1'b0;
    end
    checkOutput("stk_we", 32'(stk_we), 32'(e.we));
    checkOutput("stk_delta", 32'(stk_delta), 32'(e.delta));
    if (e.we) checkOutput("stk_wd", stk_wd, e.wd);
    checkOutput("core_stall", 32'(core_stall), 32'(e.stall));
    checkOutput("dbg_ack", 32'(bus.ack), 32'(e.ack));
    checkOutput("dbg_rdata", bus.rdata, m_rdata);
    checkOutput("depth", 32'(depth), 32'(m_depth));
    checkOutput("ovf", 32'(ovf), 32'(m_ovf));
    checkOutput("unf", 32'(unf), 32'(m_unf));
`ifdef STACK_ARB_HWM_EN
    checkOutput("hwm", 32'(hwm), 32'(m_hwm));
`endif
    if (!reset) begin
      if (e.cap) m_rdata = stk_rd;
      if (m_depth > m_hwm) m_hwm = m_depth;
      if (e.delta == 2'b01) begin
        if (m_depth == DEPTH + 1) m_ovf = 1'b1;
        else                      m_depth++;
      end else if (e.delta == 2'b11) begin
        if (m_depth == 0) m_unf = 1'b1;
        else              m_depth--;
      end
      if (e.clr_done) begin
        m_ovf = 1'b0; m_unf = 1'b0; m_hwm = 0;
      end
      if (q.size() > 0) begin
        void'(q.pop_front());
      end else if (bus.req && core_halt) begin
        case (bus.cmd)
          2'b00: q.push_back(mk(1'b0, 2'b10, '0, 1'b0, 1'b1, 1'b0));
          2'b01: q.push_back(mk(1'b1, 2'b01, bus.wd, 1'b0, 1'b0, 1'b0));
          2'b10: q.push_back(mk(1'b0, 2'b11, '0, 1'b0, 1'b1, 1'b0));
          default: begin
            for (int i = 0; i < m_depth; i++) q.push_back(mk(1'b0, 2'b11, '0, 1'b0, 1'b0, 1'b0));
            q.push_back(mk(1'b0, 2'b10, '0, 1'b0, 1'b0, 1'b1));
          end
        endcase
        q.push_back(mk(1'b0, 2'b10, '0, 1'b1, 1'b0, 1'b0));
      end
    end
  end

  // One core stack operation for one cycle, then back to idle.
  task automatic applyStimulus(input logic we, input logic [1:0] d, input logic [DW-1:0] wd);
    core_we = we; core_delta = d; core_wd = wd;
    @(posedge clk); #1;
    core_we = 1'b0; core_delta = 2'b10; core_wd = '0;
  endtask

  // Issue one debug command for one cycle; measure cycles from accept to ack.
  task automatic issueDebug(input string name, input logic [1:0] cmd, input logic [DW-1:0] wd,
                            input bit noisy, input int expLat, output int pops);
    int n;
    pops = 0;
    bus.req = 1'b1; bus.cmd = cmd; bus.wd = wd;
    @(posedge clk); #1;
    bus.req = 1'b0;
    if (noisy) begin
      core_we = 1'b1; core_delta = 2'b01; core_wd = 32'hBAD0_BAD0;
    end
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      n++;
      if (stk_delta == 2'b11) pops++;
      if (bus.ack === 1'b1) break;
    end
    checkOutput({name, "_latency"}, 32'(n), 32'(expLat));
    @(posedge clk); #1;
    core_we = 1'b0; core_delta = 2'b10; core_wd = '0;
  endtask

  // Directed sequence.
  initial begin
    int pops;
    int acks;
    reset = 1'b1;
    core_we = 1'b0; core_delta = 2'b10; core_wd = '0; core_halt = 1'b0;
    bus.req = 1'b0; bus.cmd = 2'b00; bus.wd = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_depth", 32'(depth), 0);
    checkOutput("rst_ovf", 32'(ovf), 0);
    checkOutput("rst_unf", 32'(unf), 0);
    checkOutput("rst_ack", 32'(bus.ack), 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_stall", 32'(core_stall), 0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("[TB] core push/pop");
    applyStimulus(1'b1, 2'b01, 32'h11);
    applyStimulus(1'b1, 2'b01, 32'h22);
    applyStimulus(1'b1, 2'b01, 32'h33);
    checkOutput("core_push_depth", 32'(depth), 3);
    applyStimulus(1'b0, 2'b11, '0);
    checkOutput("core_pop_depth", 32'(depth), 2);
    checkOutput("core_pop_head", stk_rd, 32'h22);
    checkOutput("core_ovf", 32'(ovf), 0);
    checkOutput("core_unf", 32'(unf), 0);

    $display("[TB] debug push/peek");
    core_halt = 1'b1;
    issueDebug("push", CMD_PUSH, 32'hDEAD_BEEF, 1'b0, 2, pops);
    checkOutput("push_depth", 32'(depth), 3);
    issueDebug("peek", CMD_PEEK, '0, 1'b0, 2, pops);
    checkOutput("peek_rdata", bus.rdata, 32'hDEAD_BEEF);
    checkOutput("peek_depth", 32'(depth), 3);
    issueDebug("clear3", CMD_CLEAR, '0, 1'b0, 5, pops);
    checkOutput("clear3_depth", 32'(depth), 0);

    $display("[TB] overflow");
    for (int i = 1; i <= 19; i++) applyStimulus(1'b1, 2'b01, 32'h100 + 32'(i));
    checkOutput("full_depth", 32'(depth), 19);
    checkOutput("full_ovf", 32'(ovf), 0);
    applyStimulus(1'b1, 2'b01, 32'h114);
    checkOutput("ovf_depth", 32'(depth), 19);
    checkOutput("ovf_flag", 32'(ovf), 1);
    issueDebug("pop", CMD_POP, '0, 1'b0, 2, pops);
    checkOutput("pop_rdata", bus.rdata, 32'h114);
    checkOutput("pop_depth", 32'(depth), 18);
    checkOutput("pop_ovf_sticky", 32'(ovf), 1);

    $display("[TB] underflow and clear at zero");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst2_ovf", 32'(ovf), 0);
    applyStimulus(1'b0, 2'b11, '0);
    checkOutput("unf_flag", 32'(unf), 1);
    checkOutput("unf_depth", 32'(depth), 0);
    issueDebug("clear0", CMD_CLEAR, '0, 1'b0, 2, pops);
    checkOutput("clear0_unf", 32'(unf), 0);

    $display("[TB] clear from depth 5 with busy core");
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 32'h200 + 32'(i));
    issueDebug("clear5", CMD_CLEAR, '0, 1'b1, 7, pops);
    checkOutput("clear5_pops", 32'(pops), 5);
    checkOutput("clear5_depth", 32'(depth), 0);

    $display("[TB] request while core running");
    core_halt = 1'b0;
    bus.req = 1'b1; bus.cmd = CMD_PUSH; bus.wd = 32'h5555_5555;
    core_we = 1'b1; core_delta = 2'b01; core_wd = 32'h77;
    acks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    @(posedge clk); #1;
    bus.req = 1'b0;
    core_we = 1'b0; core_delta = 2'b10; core_wd = '0;
    checkOutput("holdoff_acks", 32'(acks), 0);
    checkOutput("holdoff_depth", 32'(depth), 10);

    $display("[TB] reset during clear");
    core_halt = 1'b1;
    bus.req = 1'b1; bus.cmd = CMD_CLEAR;
    @(posedge clk); #1;
    bus.req = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("midclr_depth", 32'(depth), 8);
    reset = 1'b1;
    #1;
    checkOutput("abort_depth", 32'(depth), 0);
    checkOutput("abort_stall", 32'(core_stall), 0);
    checkOutput("abort_ack", 32'(bus.ack), 0);
    checkOutput("abort_delta", 32'(stk_delta), 32'(2'b10));
    @(posedge clk); #1;
    reset = 1'b0;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.ack === 1'b1) acks++;
    end
    checkOutput("abort_noack", 32'(acks), 0);
    checkOutput("abort_depth_after", 32'(depth), 0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
